serial_popcount: RTL and testbench

SERIAL_POPCOUNT -- requirements
Module: serial_popcount

---
 rtl/popcount_pkg.sv | 17 +
 rtl/serial_popcount_if.sv | 34 +++
 rtl/popcount_frame_ctr.sv | 34 +++
 rtl/serial_popcount.sv | 90 +++++++++
 tb/tb_serial_popcount.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the serial population counter.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int FRAME_LEN_DEFAULT = 8;

    // Count must reach FRAME_LEN itself, hence the +1.
    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/serial_popcount_if.sv
// Bit-stream input and count-result output handshakes of serial_popcount.
// OUT_PARITY is present only when POPCOUNT_PARITY_EN is defined.
interface serial_popcount_if
    import popcount_pkg::*;
#(
    parameter int CNT_W = cnt_width(FRAME_LEN_DEFAULT)
);
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_cnt;
`ifdef POPCOUNT_PARITY_EN
    logic             out_parity;
`endif

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_cnt
`ifdef POPCOUNT_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_cnt
`ifdef POPCOUNT_PARITY_EN
        , output out_parity
`endif
    );

endinterface

// File: rtl/popcount_frame_ctr.sv
// Bit index within a frame; wraps to 0 after the last bit, with synchronous clear.
module popcount_frame_ctr #(
    parameter int FRAME_LEN = 8,
    localparam int IDX_W = $clog2(FRAME_LEN)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    logic [IDX_W-1:0] idx_q, idx_d;

    assign last_o = (idx_q == IDX_W'(FRAME_LEN - 1));

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = last_o ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/serial_popcount.sv
// Counts the 1 bits of each FRAME_LEN-bit serial frame and holds the result until taken.
// Optional OUT_PARITY output enabled by defining POPCOUNT_PARITY_EN.
module serial_popcount
    import popcount_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_clr_i,
    serial_popcount_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             take;
    logic             last_bit;

    assign bus.in_ready  = (state_q != HOLD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_cnt   = cnt_q;
`ifdef POPCOUNT_PARITY_EN
    assign bus.out_parity = cnt_q[0];
`endif

    assign accept = bus.in_valid && bus.in_ready;
    // A frame abort wins over a bit arriving in the same cycle.
    assign take   = accept && !sync_clr_i;

    popcount_frame_ctr #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (sync_clr_i),
        .inc_i  (take),
        .last_o (last_bit)
    );

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        if (sync_clr_i) begin
            state_d = IDLE;
            ones_d  = '0;
        end else begin
            unique case (state_q)
                IDLE, ACC: begin
                    if (take) begin
                        if (last_bit) begin
                            // Publish the total including this bit; start the next frame from 0.
                            state_d = HOLD;
                            cnt_d   = ones_q + CNT_W'(bus.in_bit);
                            ones_d  = '0;
                        end else begin
                            state_d = ACC;
                            ones_d  = ones_q + CNT_W'(bus.in_bit);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ones_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ones_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_popcount.sv
// Directed self-checking bench for serial_popcount with FRAME_LEN=8.
module tb_serial_popcount;
    import popcount_pkg::*;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = cnt_width(FRAME_LEN);

    logic clk;
    logic rst_n;
    logic sync_clr;
    int   checks;
    int   errors;

    serial_popcount_if #(.CNT_W(CNT_W)) bus ();

    serial_popcount #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_clr_i (sync_clr),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input int exp_cnt);
        check({tag, "_valid"}, int'(bus.out_valid), 1);
        check({tag, "_cnt"}, int'(bus.out_cnt), exp_cnt);
        check({tag, "_in_ready"}, int'(bus.in_ready), 0);
`ifdef POPCOUNT_PARITY_EN
        check({tag, "_parity"}, int'(bus.out_parity), exp_cnt % 2);
`endif
    endtask

    // Drives 8 consecutive bits MSB first; checks the result one cycle after the 8th.
    task automatic run_frame(input string tag, input logic [7:0] bits, input int exp_cnt);
        logic [7:0] b;
        b = bits;
        for (int i = 7; i >= 0; i--) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = b[i];
            tick();
            if (i == 1) check({tag, "_early"}, int'(bus.out_valid), 0);
        end
        check_result(tag, exp_cnt);
        $display("frame %s bits=%b out_cnt=%0d expected=%0d", tag, bits, bus.out_cnt, exp_cnt);
    endtask

    // Takes the result with IN_VALID low and confirms it is released after one cycle.
    task automatic release_result(input string tag, input int last_cnt);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check({tag, "_released"}, int'(bus.out_valid), 0);
        check({tag, "_cnt_kept"}, int'(bus.out_cnt), last_cnt);
        check({tag, "_ready_again"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        logic [7:0] vb;
        int         vi;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        sync_clr      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("reset_valid", int'(bus.out_valid), 0);
        check("reset_cnt", int'(bus.out_cnt), 0);
        check("reset_in_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1;
        tick();
        check("post_reset_in_ready", int'(bus.in_ready), 1);

        // Basic frame 1,0,1,1,0,0,1,1 -> 5
        run_frame("basic", 8'b1011_0011, 5);
        release_result("basic", 5);

        // All ones then all zeros, no carry
        run_frame("ones", 8'hFF, 8);
        release_result("ones", 8);
        run_frame("zeros", 8'h00, 0);
        release_result("zeros", 0);

        // Backpressure: result held 4 cycles with IN_VALID high
        bus.out_ready = 1'b0;
        run_frame("stall", 8'b1110_0000, 3);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_in_ready", int'(bus.in_ready), 0);
            check("stall_valid", int'(bus.out_valid), 1);
            check("stall_cnt", int'(bus.out_cnt), 3);
        end
        bus.out_ready = 1'b1;
        tick();
        check("stall_handshake", int'(bus.out_valid), 0);
        // IN_VALID stays high: a bit accepted in the handshake cycle would corrupt this frame
        run_frame("after_stall", 8'b0000_0011, 2);
        release_result("after_stall", 2);

        // IN_VALID toggled; unqualified cycles carry 1s that must be ignored
        vb = 8'b1101_0011;
        vi = 7;
        for (int c = 0; c < 15; c++) begin
            if (c % 2 == 0) begin
                bus.in_valid = 1'b1;
                bus.in_bit   = vb[vi];
                vi--;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_bit   = 1'b1;
            end
            tick();
            if (c == 13) check("toggle_early", int'(bus.out_valid), 0);
        end
        check_result("toggle", 5);
        $display("frame toggle out_cnt=%0d expected=5", bus.out_cnt);
        release_result("toggle", 5);

        // Abort after 5 bits (3 ones); the abort cycle's bit must be dropped
        vb = 8'b1110_0000;
        for (int i = 7; i >= 3; i--) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = vb[i];
            tick();
        end
        sync_clr     = 1'b1;
        bus.in_bit   = 1'b1;
        tick();
        sync_clr     = 1'b0;
        check("abort_valid", int'(bus.out_valid), 0);
        check("abort_in_ready", int'(bus.in_ready), 1);
        run_frame("after_abort", 8'b1000_0001, 2);

        // Abort in HOLD discards the pending result even with OUT_READY high
        sync_clr      = 1'b1;
        bus.in_valid  = 1'b0;
        tick();
        sync_clr      = 1'b0;
        check("abort_hold_valid", int'(bus.out_valid), 0);
        check("abort_hold_cnt_kept", int'(bus.out_cnt), 2);
        check("abort_hold_in_ready", int'(bus.in_ready), 1);

        // Asynchronous reset mid-frame
        bus.out_ready = 1'b1;
        run_frame("pre_reset", 8'b1111_0000, 4);
        release_result("pre_reset", 4);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_mid_cnt", int'(bus.out_cnt), 0);
        check("async_mid_valid", int'(bus.out_valid), 0);
        #2 rst_n = 1'b1;
        tick();
        check("async_mid_in_ready", int'(bus.in_ready), 1);
        run_frame("after_mid_reset", 8'b0101_0101, 4);

        // Asynchronous reset in HOLD
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_hold_valid", int'(bus.out_valid), 0);
        check("async_hold_cnt", int'(bus.out_cnt), 0);
        check("async_hold_in_ready", int'(bus.in_ready), 1);
`ifdef POPCOUNT_PARITY_EN
        check("async_hold_parity", int'(bus.out_parity), 0);
`endif
        #2 rst_n = 1'b1;
        tick();
        check("async_hold_post_ready", int'(bus.in_ready), 1);
        run_frame("after_hold_reset", 8'b0111_0000, 3);
        release_result("after_hold_reset", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
